spatz_xmem_responder: RTL

SPATZ_XMEM_RESPONDER -- requirements
Module: spatz_xmem_responder

---
 rtl/spatz_xmem_responder_pkg.sv | 20 ++
 rtl/spatz_xmem_responder_if.sv | 54 +++++
 rtl/spatz_xmem_responder_fifo.sv | 65 ++++++
 rtl/spatz_xmem_responder.sv | 111 +++++++++++
 4 files changed

// File: rtl/spatz_xmem_responder_pkg.sv
// Shared widths and result record for the Spatz X-interface memory responder.
package spatz_pkg;

  localparam int unsigned XIdWidth   = 4;
  localparam int unsigned XDataWidth = 32;
  localparam int unsigned XAddrWidth = 32;
  localparam int unsigned XBeWidth   = XDataWidth / 8;

  typedef struct packed {
    logic [XDataWidth-1:0] rdata;
    logic [XIdWidth-1:0]   id;
    logic                  err;
  } xmem_result_t;

  // Word accesses only: any nonzero byte offset is an exception.
  function automatic logic is_misaligned(input logic [XAddrWidth-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/spatz_xmem_responder_if.sv
// X-interface request/result bus (Spatz side is master) and the memory-port bus
// (responder side is master).
interface spatz_xmem_responder_if
  import spatz_pkg::*;
#(
  parameter int unsigned IdWidth = XIdWidth
);
  logic                  valid;
  logic                  ready;
  logic [XAddrWidth-1:0] addr;
  logic                  we;
  logic [XBeWidth-1:0]   be;
  logic [XDataWidth-1:0] wdata;
  logic [IdWidth-1:0]    id;
  logic                  resp_exc;
  logic                  result_valid;
  logic [XDataWidth-1:0] result_rdata;
  logic [IdWidth-1:0]    result_id;
  logic                  result_err;

  modport master (
    output valid, addr, we, be, wdata, id,
    input  ready, resp_exc, result_valid, result_rdata, result_id, result_err
  );

  modport slave (
    input  valid, addr, we, be, wdata, id,
    output ready, resp_exc, result_valid, result_rdata, result_id, result_err
  );
endinterface

interface spatz_mem_if
  import spatz_pkg::*;
;
  logic                  req;
  logic                  gnt;
  logic [XAddrWidth-1:0] addr;
  logic                  we;
  logic [XBeWidth-1:0]   be;
  logic [XDataWidth-1:0] wdata;
  logic                  rvalid;
  logic [XDataWidth-1:0] rdata;
  logic                  err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/spatz_xmem_responder_fifo.sv
// Generic synchronous FIFO with occupancy output; pushes when full and pops
// when empty are ignored. Combinational read of the head entry.
module fifo_v3 #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 4,
  localparam int unsigned AddrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [AddrW:0]        usage_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]        cnt_q, cnt_d;
  logic                  push_ok, pop_ok;

  assign push_ok = push_i & (cnt_q != (AddrW+1)'(DEPTH));
  assign pop_ok  = pop_i & (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Explicit wrap keeps pointers modulo DEPTH even for non-power-of-two depths.
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == AddrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == AddrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign usage_o = cnt_q;

endmodule

// File: rtl/spatz_xmem_responder.sv
// Bridges Spatz X-interface memory requests onto an in-order memory port and
// returns one result per aligned accept, one cycle after the memory response.
module spatz_xmem_responder
  import spatz_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned IdWidth        = XIdWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  spatz_xmem_responder_if.slave   x_mem,
  spatz_mem_if.master             mem,
  output logic                    busy_o
);

  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;

  logic [CntW-1:0]    outstanding;
  logic [IdWidth-1:0] pop_id;
  logic               misaligned, full, empty;
  logic               push, pop;

  // Store flags ride alongside the ID FIFO so store results can be zeroed.
  logic [MaxOutstanding-1:0] we_q, we_d;
  logic [PtrW-1:0]           we_wr_q, we_wr_d;
  logic [PtrW-1:0]           we_rd_q, we_rd_d;

  xmem_result_t result_q, result_d;
  logic         result_valid_q, result_valid_d;

  assign misaligned = is_misaligned(x_mem.addr);
  assign full       = (outstanding == CntW'(MaxOutstanding));
  assign empty      = (outstanding == '0);

  assign mem.req        = ~rst_i & x_mem.valid & ~misaligned & ~full;
  assign x_mem.ready    = ~rst_i & ~full & (misaligned | mem.gnt);
  assign x_mem.resp_exc = ~rst_i & x_mem.valid & misaligned & ~full;

  assign mem.addr  = x_mem.addr;
  assign mem.we    = x_mem.we;
  assign mem.be    = x_mem.be;
  assign mem.wdata = x_mem.wdata;

  assign push = mem.req & mem.gnt;
  assign pop  = ~rst_i & mem.rvalid & ~empty;

  fifo_v3 #(
    .DEPTH      (MaxOutstanding),
    .DATA_WIDTH (IdWidth)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (x_mem.id),
    .pop_i   (pop),
    .data_o  (pop_id),
    .usage_o (outstanding)
  );

  always_comb begin
    we_d           = we_q;
    we_wr_d        = we_wr_q;
    we_rd_d        = we_rd_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    if (push) begin
      we_d[we_wr_q] = x_mem.we;
      we_wr_d       = we_wr_q + 1'b1;
    end
    if (pop) begin
      we_rd_d        = we_rd_q + 1'b1;
      result_valid_d = 1'b1;
      result_d.id    = pop_id;
      result_d.rdata = we_q[we_rd_q] ? '0 : mem.rdata;
      result_d.err   = mem.err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q           <= '0;
      we_wr_q        <= '0;
      we_rd_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      we_q           <= we_d;
      we_wr_q        <= we_wr_d;
      we_rd_q        <= we_rd_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign x_mem.result_valid = result_valid_q;
  assign x_mem.result_rdata = result_q.rdata;
  assign x_mem.result_id    = result_q.id;
  assign x_mem.result_err   = result_q.err;

  assign busy_o = ~rst_i & (~empty | result_valid_q);

  // A response with nothing outstanding (e.g. after a mid-flight reset) is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(mem.rvalid && empty))
        else $warning("xmem responder: memory response with no outstanding request dropped");
    end
  end

endmodule
